// File: rtl/nf10_axis_downsizer_256_64.sv
// nf10_axis_downsizer_256_64: serialises wide internal AXI4-Stream words into narrow port-side beats
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   S_AXIS_*            256-bit slave stream (TDATA/TSTRB/TUSER/TLAST/TVALID/TREADY)
//   M_AXIS_*            64-bit master stream, lane 0 first, TUSER repeated on every beat
module nf10_axis_downsizer_256_64 #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_M_AXIS_TDATA_WIDTH = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY
);
    localparam int RATIO = C_S_AXIS_TDATA_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int LW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int MSW = C_M_AXIS_TDATA_WIDTH / 8;
    typedef enum logic {EMPTY, SEND} state_t;
    state_t state_q, state_d;
    logic [RATIO-1:0][C_M_AXIS_TDATA_WIDTH-1:0] data_q, data_d;
    logic [RATIO-1:0][MSW-1:0] strb_q, strb_d, s_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] user_q, user_d;
    logic last_q, last_d;
    logic [LW-1:0] lane_q, lane_d, last_lane_q, last_lane_d, load_last_lane;
    logic at_last, s_hs, m_hs;
    assign s_strb = S_AXIS_TSTRB;
    assign at_last = lane_q == last_lane_q;
    // Ready looks through to M_AXIS_TREADY so a new word loads as the final lane leaves
    assign S_AXIS_TREADY = !ARESET && (state_q == EMPTY || (M_AXIS_TREADY && at_last));
    assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_hs = state_q == SEND && M_AXIS_TREADY;
    assign M_AXIS_TVALID = state_q == SEND;
    assign M_AXIS_TDATA = data_q[lane_q];
    assign M_AXIS_TSTRB = strb_q[lane_q];
    assign M_AXIS_TUSER = user_q;
    assign M_AXIS_TLAST = last_q && at_last;
    // Highest lane carrying any strobe; an all-zero word still emits lane 0
    always_comb begin
        load_last_lane = '0;
        for (int k = 0; k < RATIO; k++)
            if (|s_strb[k]) load_last_lane = LW'(k);
    end
    always_comb begin
        state_d = state_q;
        data_d = data_q;
        strb_d = strb_q;
        user_d = user_q;
        last_d = last_q;
        lane_d = lane_q;
        last_lane_d = last_lane_q;
        if (s_hs) begin
            state_d = SEND;
            data_d = S_AXIS_TDATA;
            strb_d = S_AXIS_TSTRB;
            user_d = S_AXIS_TUSER;
            last_d = S_AXIS_TLAST;
            lane_d = '0;
            last_lane_d = load_last_lane;
        end else if (m_hs) begin
            lane_d = at_last ? lane_q : lane_q + 1'b1;
            state_d = at_last ? EMPTY : SEND;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= EMPTY;
            data_q <= '0;
            strb_q <= '0;
            user_q <= '0;
            last_q <= 1'b0;
            lane_q <= '0;
            last_lane_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            strb_q <= strb_d;
            user_q <= user_d;
            last_q <= last_d;
            lane_q <= lane_d;
            last_lane_q <= last_lane_d;
        end
    end
endmodule

// File: tb/tb_nf10_axis_downsizer_256_64.sv
// tb_nf10_axis_downsizer_256_64: table vectors plus scoreboard for the 256-to-64 downsizer
module tb_nf10_axis_downsizer_256_64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [255:0] s_tdata = '0;
    logic [31:0] s_tstrb = '0;
    logic [127:0] s_tuser = '0;
    logic s_tlast = 1'b0;
    logic s_tvalid = 1'b0;
    logic s_tready;
    logic [63:0] m_tdata;
    logic [7:0] m_tstrb;
    logic [127:0] m_tuser;
    logic m_tlast;
    logic m_tvalid;
    logic m_tready = 1'b1;
    nf10_axis_downsizer_256_64 dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [255:0] d;
        logic [31:0] s;
        logic [127:0] u;
        logic l;
        int mode;
        int exp_beats;
    } vec_t;
    typedef struct {
        logic [63:0] d;
        logic [7:0] s;
        logic [127:0] u;
        logic l;
        logic fin;
    } beat_t;
    beat_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int mode = 0;
    int beats = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int s_acc = 0;
    task automatic check(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask
    function automatic void push_word(input logic [255:0] d, input logic [31:0] s,
                                      input logic [127:0] u, input logic l);
        int ll = 0;
        for (int k = 0; k < 4; k++) if (|s[k*8 +: 8]) ll = k;
        for (int k = 0; k <= ll; k++)
            q.push_back('{d[k*64 +: 64], s[k*8 +: 8], u, l && (k == ll), k == ll});
    endfunction
    // Downstream ready pattern: 0 always, 1 alternating, 2 random
    always @(posedge clk) begin
        #1;
        m_tready = mode == 0 ? 1'b1 : mode == 1 ? !m_tready : 1'($urandom_range(0, 1));
    end
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (m_tvalid) begin
                if (q.size() == 0) begin
                    check("m_valid_spurious", m_tvalid, 0);
                end else begin
                    check("m_tdata", m_tdata, q[0].d);
                    check("m_tstrb", m_tstrb, q[0].s);
                    check("m_tuser", m_tuser, q[0].u);
                    check("m_tlast", m_tlast, q[0].l);
                    check("s_tready_busy", s_tready, m_tready && q[0].fin);
                    if (m_tready) begin
                        if (beats == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        beats++;
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("m_valid_pending", m_tvalid, q.size() != 0);
                check("s_tready_idle", s_tready, 1);
            end
            if (s_tvalid && s_tready) begin
                s_acc++;
                push_word(s_tdata, s_tstrb, s_tuser, s_tlast);
            end
        end
    end
    task automatic send(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
        int t = 0;
        s_tdata = d;
        s_tstrb = s;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("s_accept", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask
    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || m_tvalid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", t < 500, 1);
        @(posedge clk);
        #1;
    endtask
    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    vec_t tv[9];
    initial begin
        logic [255:0] full_d;
        int t;
        full_d = {64'hD3D3_3333_0000_0003, 64'hD2D2_2222_0000_0002,
                  64'hD1D1_1111_0000_0001, 64'hD0D0_0000_0000_0000};
        tv[0] = '{full_d, 32'hFFFF_FFFF, 128'hA1, 1'b1, 0, 4};
        tv[1] = '{rnd256(), 32'hFFFF_FFFF, 128'hB2, 1'b0, 0, 4};
        tv[2] = '{rnd256(), 32'h0FFF_FFFF, 128'hC3, 1'b1, 0, 4};
        tv[3] = '{rnd256(), 32'h0000_00FF, 128'hD4, 1'b1, 0, 1};
        tv[4] = '{rnd256(), 32'h0000_0000, 128'hE5, 1'b1, 0, 1};
        tv[5] = '{rnd256(), 32'h0000_0000, 128'hF6, 1'b0, 0, 1};
        tv[6] = '{rnd256(), 32'h00FF_00F0, 128'h17, 1'b1, 2, 3};
        tv[7] = '{full_d, 32'hFFFF_FFFF, 128'h28, 1'b1, 1, 4};
        tv[8] = '{rnd256(), 32'h0000_FF00, 128'h39, 1'b0, 2, 2};
        s_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tstrb", m_tstrb, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_s_tready", s_tready, 0);
        s_tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        foreach (tv[i]) begin
            mode = tv[i].mode;
            beats = 0;
            send(tv[i].d, tv[i].s, tv[i].u, tv[i].l);
            drain();
            check($sformatf("vec%0d_beats", i), beats, tv[i].exp_beats);
        end
        mode = 0;
        beats = 0;
        send(rnd256(), 32'h0000_00FF, 128'h44, 1'b1);
        send(full_d, 32'hFFFF_FFFF, 128'h55, 1'b1);
        drain();
        check("short_then_full_beats", beats, 5);
        beats = 0;
        s_acc = 0;
        for (int i = 0; i < 16; i++) send(rnd256(), 32'hFFFF_FFFF, 128'(i), i == 15);
        drain();
        check("stream_beats", beats, 64);
        check("stream_span", last_cyc - first_cyc + 1, 64);
        check("stream_accepts", s_acc, 16);
        beats = 0;
        send(full_d, 32'hFFFF_FFFF, 128'h66, 1'b1);
        t = 0;
        while (beats < 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("reset_wait", beats, 2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_m_tdata", m_tdata, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        beats = 0;
        send({64'h3, 64'h2, 64'h1, 64'hCAFE}, 32'hFFFF_FFFF, 128'h77, 1'b1);
        drain();
        check("post_rst_beats", beats, 4);
        check("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nf10_axis_downsizer_256_64.md
Name: nf10_axis_downsizer_256_64

Overview:
AXI4-Stream width converter, transmit direction. It takes 256-bit internal pipeline words, already in internal byte order, and serialises them into 64-bit beats for a 10G port-side interface. Packet boundaries, TSTRB and TUSER metadata are preserved. It sits between the internal datapath and the port interface, and is the egress counterpart of the port-side 64-to-256 ingress path.

Parameters:
C_S_AXIS_TDATA_WIDTH, 256, input data width. Must be an integer power-of-2 multiple of C_M_AXIS_TDATA_WIDTH.
C_M_AXIS_TDATA_WIDTH, 64, output data width. RATIO = C_S/C_M; 4 at defaults.
C_S_AXIS_TUSER_WIDTH, 128, input TUSER width.
C_M_AXIS_TUSER_WIDTH, 128, output TUSER width. Must equal the input width.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AXIS_TDATA  in  256  input word
S_AXIS_TSTRB  in  32  input byte strobes
S_AXIS_TUSER  in  128  input metadata
S_AXIS_TLAST  in  1  last word of packet
S_AXIS_TVALID  in  1  input valid
S_AXIS_TREADY  out  1  input ready
M_AXIS_TDATA  out  64  output beat
M_AXIS_TSTRB  out  8  output strobes
M_AXIS_TUSER  out  128  output metadata
M_AXIS_TLAST  out  1  last beat of packet
M_AXIS_TVALID  out  1  output valid
M_AXIS_TREADY  in  1  downstream ready

Behaviour:
- Reset (ARESET=1, asynchronous):
  - M_AXIS_TVALID, TLAST, TDATA, TSTRB and TUSER all clear to 0.
  - Lane counter clears to 0; state goes to EMPTY.
  - S_AXIS_TREADY is forced 0 while ARESET is high.
  - Reset mid-packet discards the held word and any remaining lanes. The first word after reset starts at lane 0.
- Storage: one holding register (data, strobes, TUSER, TLAST), a lane index of log2(RATIO) bits, and last_lane.
- last_lane is computed at load time as the highest lane with any nonzero strobe bit; it is 0 if all strobes are zero.
- States:
  - EMPTY: M_AXIS_TVALID=0. On S handshake, load the register, set lane=0 and go to SEND.
  - SEND: M_AXIS_TVALID=1.
    - On M handshake with lane<last_lane: lane increments.
    - On M handshake with lane==last_lane: if an S handshake occurs in the same cycle, load the new word, set lane=0 and stay in SEND; otherwise go to EMPTY.
- S_AXIS_TREADY = !ARESET && (state==EMPTY || (M_AXIS_TREADY && lane==last_lane)). It is combinational from M_AXIS_TREADY, which is required for full throughput.
- Latency: first output beat is valid the cycle after input acceptance. There are no bubbles between words when both sides are always ready.
- Lane order: lane k drives M_AXIS_TDATA = held[64k+63:64k] and M_AXIS_TSTRB = strb[8k+7:8k]. Lane 0 is emitted first.
- M_AXIS_TUSER carries the held word's TUSER unchanged on every beat of that word.
- M_AXIS_TLAST = held TLAST && lane==last_lane.
- Lanes above last_lane are never emitted. This applies to both last and non-last words.
- All-zero strobe word:
  - With TLAST=1: emit exactly one beat (lane 0, TSTRB=0x00, TLAST=1) so the packet terminates.
  - With TLAST=0: emit one beat (lane 0, TSTRB=0x00, TLAST=0).
- Non-contiguous strobes are passed through lane-wise as received; there is no compaction.
- AXI rules:
  - Output TDATA, TSTRB, TUSER and TLAST are stable while TVALID=1 and TREADY=0.
  - TVALID never drops without a handshake except on reset.
  - TVALID does not depend combinationally on TREADY.
- S_AXIS_TVALID dropping or toggling while TREADY=0 causes no effect.

Test Plan:
- Single full word: TDATA=0x{D3,D2,D1,D0} (each 64-bit), TSTRB=0xFFFFFFFF, TLAST=1, M_TREADY=1 → 4 beats D0,D1,D2,D3, each TSTRB=0xFF; TLAST only on D3; first beat one cycle after acceptance.
- 60-byte packet: word0 TSTRB=0xFFFFFFFF TLAST=0, then word1 TSTRB=0x0FFFFFFF TLAST=1 → 8 beats; beat 8 TSTRB=0x0F with TLAST=1; beats 1–7 TSTRB=0xFF; TUSER constant across all beats within each word.
- Short last word: TSTRB=0x000000FF TLAST=1, next word presented immediately → one beat TSTRB=0xFF TLAST=1; S_AXIS_TREADY=1 in the same cycle; next word's lane 0 appears the following cycle.
- Back-pressure: M_AXIS_TREADY pattern 1,0,1,0,… over a full word → each lane held stable until accepted; no lane dropped or duplicated; S_AXIS_TREADY=0 until the lane-3 handshake.
- Streaming: 16 back-to-back full words, M_AXIS_TREADY=1 → M_AXIS_TVALID high continuously for 64 cycles; S_AXIS_TREADY high once every 4 cycles.
- Reset and zero strobe:
  - Assert ARESET after lane 1 is accepted → M_AXIS_TVALID=0 immediately. After release, the new word is emitted starting at lane 0.
  - A TSTRB=0 TLAST=1 word → single beat TSTRB=0x00 TLAST=1.
